// File: rtl/mdu_issue_ctrl.sv
// EX-stage issue/handshake controller for the multicycle multiplier; owns HI/LO.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB accumulation into HI/LO.
module mdu_issue_ctrl #(
   parameter int DRAIN_CYCLES = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   input  logic        flush_i,
   output logic        start_o,
   output logic        signed_o,
   output logic [31:0] opdata1_o,
   output logic [31:0] opdata2_o,
   input  logic [63:0] result_i,
   input  logic        ready_i,
   output logic        stallreq_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_MTHI  = 3'b011;
   localparam logic [2:0] OP_MTLO  = 3'b100;
`ifdef MDU_MADD_EN
   localparam logic [2:0] OP_MADD  = 3'b101;
   localparam logic [2:0] OP_MADDU = 3'b110;
   localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_ABORT} state_t;
   typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;

   state_t      state, state_n;
   acc_t        acc_mode, acc_mode_n, dec_acc;
   logic [CW-1:0] drain_cnt, drain_cnt_n;
   logic        signed_q, signed_n, dec_signed;
   logic [31:0] op1_q, op1_n, op2_q, op2_n;
   logic [31:0] hi_q, hi_n, lo_q, lo_n;
   logic        is_mul, is_mt, is_mdu;
   logic [63:0] wb_value;

   assign start_o   = (state == S_BUSY);
   assign signed_o  = signed_q;
   assign opdata1_o = op1_q;
   assign opdata2_o = op2_q;
   assign hi_o      = hi_q;
   assign lo_o      = lo_q;

   always_comb begin
      is_mul     = 1'b0;
      dec_signed = 1'b0;
      dec_acc    = ACC_NONE;
      case (op_i)
         OP_MULT:  begin is_mul = 1'b1; dec_signed = 1'b1; end
         OP_MULTU: is_mul = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD:  begin is_mul = 1'b1; dec_signed = 1'b1; dec_acc = ACC_ADD; end
         OP_MADDU: begin is_mul = 1'b1; dec_acc = ACC_ADD; end
         OP_MSUB:  begin is_mul = 1'b1; dec_signed = 1'b1; dec_acc = ACC_SUB; end
`endif
         default: ;
      endcase
      is_mt  = (op_i == OP_MTHI) || (op_i == OP_MTLO);
      is_mdu = is_mul || is_mt;
   end

   // Accumulate base is HI/LO as they stand at the write-back edge.
   always_comb begin
      case (acc_mode)
         ACC_ADD: wb_value = {hi_q, lo_q} + result_i;
         ACC_SUB: wb_value = {hi_q, lo_q} - result_i;
         default: wb_value = result_i;
      endcase
   end

   always_comb begin
      state_n     = state;
      acc_mode_n  = acc_mode;
      drain_cnt_n = drain_cnt;
      signed_n    = signed_q;
      op1_n       = op1_q;
      op2_n       = op2_q;
      hi_n        = hi_q;
      lo_n        = lo_q;
      stallreq_o  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!flush_i) begin
               if (is_mul) begin
                  stallreq_o = 1'b1;
                  op1_n      = rs_i;
                  op2_n      = rt_i;
                  signed_n   = dec_signed;
                  acc_mode_n = dec_acc;
                  state_n    = S_BUSY;
               end else if (op_i == OP_MTHI) begin
                  hi_n = rs_i;
               end else if (op_i == OP_MTLO) begin
                  lo_n = rs_i;
               end
            end
         end
         S_BUSY: begin
            stallreq_o = !ready_i;
            // A flush beats a same-cycle ready: the product is discarded.
            if (flush_i) begin
               state_n     = S_ABORT;
               drain_cnt_n = DRAIN_LOAD;
            end else if (ready_i) begin
               {hi_n, lo_n} = wb_value;
               state_n      = S_DONE;
            end
         end
         S_DONE: begin
            stallreq_o = is_mdu;
            state_n    = S_IDLE;
         end
         S_ABORT: begin
            stallreq_o = is_mdu;
            if (drain_cnt == '0) state_n = S_IDLE;
            else drain_cnt_n = drain_cnt - CW'(1);
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         acc_mode  <= ACC_NONE;
         drain_cnt <= '0;
         signed_q  <= 1'b0;
         op1_q     <= '0;
         op2_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state     <= state_n;
         acc_mode  <= acc_mode_n;
         drain_cnt <= drain_cnt_n;
         signed_q  <= signed_n;
         op1_q     <= op1_n;
         op2_q     <= op2_n;
         hi_q      <= hi_n;
         lo_q      <= lo_n;
      end
   end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl with a behavioural start/ready multiplier.
// Expectations follow MDU_MADD_EN when it is defined.
module tb_mdu_issue_ctrl;

   localparam int DRAIN = 5;
   localparam logic [2:0] OP_NONE = 3'b000, OP_MULT = 3'b001, OP_MULTU = 3'b010,
                          OP_MTHI = 3'b011, OP_MTLO = 3'b100, OP_MADD = 3'b101,
                          OP_MSUB = 3'b111;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  op_i;
   logic [31:0] rs_i, rt_i;
   logic        flush_i;
   logic        start_o, signed_o, stallreq_o;
   logic [31:0] opdata1_o, opdata2_o, hi_o, lo_o;
   logic [63:0] result_i;
   logic        ready_i;

   int errors = 0;
   int checks = 0;
   int mul_latches = 0;
   int mul_expected = 0;
   logic [63:0] exp_q[$];
   logic [63:0] model = '0;

   mdu_issue_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
      .clk(clk), .rst(rst), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i), .flush_i(flush_i),
      .start_o(start_o), .signed_o(signed_o), .opdata1_o(opdata1_o), .opdata2_o(opdata2_o),
      .result_i(result_i), .ready_i(ready_i), .stallreq_o(stallreq_o),
      .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_product(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb;
      ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
      eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
      return ea * eb;
   endfunction

   // Multiplier: latch on start, count 3 cycles, then hold ready until start drops.
   typedef enum logic [1:0] {M_FREE, M_COUNT, M_END} mstate_t;
   mstate_t     m_state = M_FREE;
   logic [1:0]  m_cnt = '0;
   logic [63:0] m_res = '0;

   always @(posedge clk) begin
      case (m_state)
         M_FREE: if (start_o) begin
            m_res       <= ref_product(signed_o, opdata1_o, opdata2_o);
            m_cnt       <= 2'd2;
            m_state     <= M_COUNT;
            mul_latches <= mul_latches + 1;
         end
         M_COUNT: if (m_cnt == 2'd0) m_state <= M_END; else m_cnt <= m_cnt - 2'd1;
         default: if (!start_o) m_state <= M_FREE;
      endcase
   end

   assign ready_i  = (m_state == M_END);
   assign result_i = m_res;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Holds the op on op_i until the pipeline is no longer stalled, then checks HI/LO.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [63:0] exp_hilo, input int exp_stall,
                                input logic exp_signed, input bit is_mul);
      int stalls = 0;
      logic [63:0] expv;
      exp_q.push_back(exp_hilo);
      model = exp_hilo;
      if (is_mul) mul_expected++;
      op_i = op; rs_i = rs; rt_i = rt;
      #1;
      while (stallreq_o) begin
         if (start_o) begin
            checkOutput("opdata1", {32'b0, opdata1_o}, {32'b0, rs});
            checkOutput("opdata2", {32'b0, opdata2_o}, {32'b0, rt});
            checkOutput("signed", {63'b0, signed_o}, {63'b0, exp_signed});
         end
         stalls++;
         if (stalls > 60) begin
            checkOutput("stall_timeout", 64'd1, 64'd0);
            break;
         end
         @(negedge clk); #1;
      end
      checkOutput("stall_cycles", 64'(stalls), 64'(exp_stall));
      @(negedge clk);
      op_i = OP_NONE;
      #1;
      expv = exp_q.pop_front();
      checkOutput("hilo", {hi_o, lo_o}, expv);
      checkOutput("start_after", {63'b0, start_o}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] a, b;
      logic [2:0]  rop;
      rst = 1'b1; op_i = OP_NONE; rs_i = '0; rt_i = '0; flush_i = 1'b0;
      idle(2);
      checkOutput("rst_start", {63'b0, start_o}, 64'd0);
      checkOutput("rst_signed", {63'b0, signed_o}, 64'd0);
      checkOutput("rst_stall", {63'b0, stallreq_o}, 64'd0);
      checkOutput("rst_opdata", {opdata1_o, opdata2_o}, 64'd0);
      checkOutput("rst_hilo", {hi_o, lo_o}, 64'd0);
      rst = 1'b0;
      idle(1);

      applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 5, 1'b1, 1'b1);
      idle(2);
      applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 5, 1'b0, 1'b1);
      idle(2);

      applyStimulus(OP_MTHI, 32'h12345678, 32'd0, {32'h12345678, model[31:0]}, 0, 1'b0, 1'b0);
      applyStimulus(OP_MTLO, 32'h9ABCDEF0, 32'd0, 64'h12345678_9ABCDEF0, 0, 1'b0, 1'b0);
      idle(1);

      // Flush in IDLE: op ignored
      op_i = OP_MTHI; rs_i = 32'hDEADBEEF; flush_i = 1'b1;
      #1;
      checkOutput("idle_flush_stall", {63'b0, stallreq_o}, 64'd0);
      @(negedge clk);
      op_i = OP_NONE; flush_i = 1'b0;
      #1;
      checkOutput("idle_flush_hilo", {hi_o, lo_o}, model);
      idle(1);

      // Flush two cycles into BUSY, then reissue through the drain window
      op_i = OP_MULT; rs_i = 32'd7; rt_i = 32'd6;
      mul_expected++;
      idle(3);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0; op_i = OP_NONE;
      #1;
      checkOutput("busy_flush_hilo", {hi_o, lo_o}, model);
      checkOutput("busy_flush_start", {63'b0, start_o}, 64'd0);
      applyStimulus(OP_MULT, 32'd7, 32'd6, 64'd42, DRAIN + 5, 1'b1, 1'b1);
      idle(2);

      // Back-to-back: second op waits out the DONE cycle
      applyStimulus(OP_MULT, 32'd100, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFED4, 5, 1'b1, 1'b1);
      applyStimulus(OP_MULTU, 32'h80000000, 32'd4, 64'h00000002_00000000, 6, 1'b0, 1'b1);
      idle(2);

      // Flush coinciding with ready: product dropped, MTLO waits for the drain
      op_i = OP_MULT; rs_i = 32'd9; rt_i = 32'd9;
      mul_expected++;
      idle(5);
      checkOutput("ready_seen", {63'b0, ready_i}, 64'd1);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0; op_i = OP_NONE;
      #1;
      checkOutput("ready_flush_hilo", {hi_o, lo_o}, model);
      applyStimulus(OP_MTLO, 32'h55AA55AA, 32'd0, {model[63:32], 32'h55AA55AA}, DRAIN, 1'b0, 1'b0);
      idle(2);

      for (int i = 0; i < 4; i++) begin
         a = $urandom; b = $urandom;
         rop = (i % 2 == 0) ? OP_MULT : OP_MULTU;
         applyStimulus(rop, a, b, ref_product(rop == OP_MULT, a, b), 5, rop == OP_MULT, 1'b1);
         idle(2);
      end

      applyStimulus(OP_MTHI, 32'd0, 32'd0, {32'd0, model[31:0]}, 0, 1'b0, 1'b0);
      applyStimulus(OP_MTLO, 32'd10, 32'd0, 64'd10, 0, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
      applyStimulus(OP_MADD, 32'd2, 32'd3, 64'd16, 5, 1'b1, 1'b1);
      idle(2);
      applyStimulus(OP_MSUB, 32'd4, 32'd5, 64'hFFFFFFFF_FFFFFFFC, 5, 1'b1, 1'b1);
`else
      applyStimulus(OP_MADD, 32'd2, 32'd3, 64'd10, 0, 1'b0, 1'b0);
      applyStimulus(OP_MSUB, 32'd4, 32'd5, 64'd10, 0, 1'b0, 1'b0);
`endif
      idle(2);

      // Reset in the middle of a multiply
      op_i = OP_MULT; rs_i = 32'd3; rt_i = 32'd4;
      mul_expected++;
      idle(2);
      rst = 1'b1; op_i = OP_NONE;
      idle(1);
      checkOutput("midrst_start", {63'b0, start_o}, 64'd0);
      checkOutput("midrst_stall", {63'b0, stallreq_o}, 64'd0);
      checkOutput("midrst_hilo", {hi_o, lo_o}, 64'd0);
      checkOutput("midrst_opdata", {opdata1_o, opdata2_o}, 64'd0);
      rst = 1'b0;
      model = '0;
      idle(8);
      checkOutput("mult_free", {62'b0, m_state}, {62'b0, M_FREE});

      checkOutput("mul_starts", 64'(mul_latches), 64'(mul_expected));
      checkOutput("queue_left", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
